// File: rtl/rv_pkg.sv
// +----------------------------------------------------------------------+
// | rv_pkg : shared RISC-V integer register file dimensions              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package rv_pkg;

   localparam int DATA_W   = 32;
   localparam int ADDR_W   = 5;
   localparam int NUM_REGS = 2 ** ADDR_W;

endpackage : rv_pkg

`default_nettype wire

// File: rtl/reg_file_rdport.sv
// +----------------------------------------------------------------------+
// | reg_file_rdport : read-port select (x0 zeroing + write forwarding)   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module reg_file_rdport #(
   parameter int DATA_W = rv_pkg::DATA_W,
   parameter int ADDR_W = rv_pkg::ADDR_W,
   parameter int BYPASS = 1
) (
   input  logic [ADDR_W-1:0] raddr,
   input  logic [DATA_W-1:0] stored,
   input  logic              fwd_en,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   localparam bit C_BYPASS_EN = (BYPASS != 0);

   // x0 wins over forwarding; fwd_en already excludes reset and x0 writes.
   always_comb begin
      rdata = stored;
      if (raddr == '0) begin
         rdata = '0;
      end else if (C_BYPASS_EN && fwd_en && (raddr == waddr)) begin
         rdata = wdata;
      end
   end

endmodule : reg_file_rdport

`default_nettype wire

// File: rtl/reg_file.sv
// +----------------------------------------------------------------------+
// | reg_file : 2**ADDR_W x DATA_W register file, 2 comb reads, 1 write  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module reg_file #(
   parameter int DATA_W = rv_pkg::DATA_W,
   parameter int ADDR_W = rv_pkg::ADDR_W,
   parameter int BYPASS = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wren,
   input  logic [DATA_W-1:0] wd,
   input  logic [ADDR_W-1:0] rr1,
   input  logic [ADDR_W-1:0] rr2,
   input  logic [ADDR_W-1:0] wr,
   output logic [DATA_W-1:0] rd1,
   output logic [DATA_W-1:0] rd2
);

   localparam int C_DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] r_regs [C_DEPTH];
   logic              w_wr_en;
   logic              w_fwd_en;

   assign w_wr_en  = wren && (wr != '0);
   assign w_fwd_en = w_wr_en && !rst;

   // Flop array so reads stay combinational; x0 is cleared by reset and never written.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < C_DEPTH; i++) begin
            r_regs[i] <= '0;
         end
      end else if (w_wr_en) begin
         r_regs[wr] <= wd;
      end
   end

   reg_file_rdport #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .BYPASS (BYPASS)
   ) u_rdport1 (
      .raddr  (rr1),
      .stored (r_regs[rr1]),
      .fwd_en (w_fwd_en),
      .waddr  (wr),
      .wdata  (wd),
      .rdata  (rd1)
   );

   reg_file_rdport #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .BYPASS (BYPASS)
   ) u_rdport2 (
      .raddr  (rr2),
      .stored (r_regs[rr2]),
      .fwd_en (w_fwd_en),
      .waddr  (wr),
      .wdata  (wd),
      .rdata  (rd2)
   );

endmodule : reg_file

`default_nettype wire

// File: tb/tb_reg_file.sv
// +----------------------------------------------------------------------+
// | tb_reg_file : scoreboard bench for reg_file against an array model   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_reg_file;

   localparam int C_DW     = 32;
   localparam int C_AW     = 5;
   localparam int C_BYPASS = 1;

   typedef struct {
      string      name;
      logic [31:0] exp1;
      logic [31:0] exp2;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wren = 1'b0;
   logic [31:0] wd = '0;
   logic [4:0]  rr1 = '0;
   logic [4:0]  rr2 = '0;
   logic [4:0]  wr = '0;
   logic [31:0] rd1;
   logic [31:0] rd2;

   logic [31:0] model [32];
   exp_t        exp_q [$];
   int          n_checks = 0;
   int          n_fails = 0;

   reg_file #(
      .DATA_W (C_DW),
      .ADDR_W (C_AW),
      .BYPASS (C_BYPASS)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .wren (wren),
      .wd   (wd),
      .rr1  (rr1),
      .rr2  (rr2),
      .wr   (wr),
      .rd1  (rd1),
      .rd2  (rd2)
   );

   always #5 clk = ~clk;

   // Architectural state: what x0..x31 hold after each edge.
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) model[i] <= '0;
      end else if (wren && wr != 0) begin
         model[wr] <= wd;
      end
   end

   function automatic logic [31:0] expect_rd(input logic [4:0] a);
      if (a == 0) return 32'h0;
      if (C_BYPASS != 0 && wren && !rst && wr == a) return wd;
      return model[a];
   endfunction

   // Called right after a falling edge: drive reads, queue expectation, hold one cycle.
   task automatic read_chk(input string nm, input logic [4:0] a1, input logic [4:0] a2);
      exp_t e;
      rr1 = a1;
      rr2 = a2;
      e.name = nm;
      e.exp1 = expect_rd(a1);
      e.exp2 = expect_rd(a2);
      exp_q.push_back(e);
      @(negedge clk);
   endtask

   task automatic set_wr(input logic en, input logic [4:0] a, input logic [31:0] d);
      wren = en;
      wr   = a;
      wd   = d;
   endtask

   // Monitor: sample the combinational outputs 1 time unit after each queued request.
   initial begin
      exp_t e;
      forever begin
         wait (exp_q.size() != 0);
         #1;
         e = exp_q.pop_front();
         n_checks++;
         if (rd1 !== e.exp1) begin
            n_fails++;
            $display("FAIL %s rd1 (rr1=%0d): got %h expected %h", e.name, rr1, rd1, e.exp1);
         end
         n_checks++;
         if (rd2 !== e.exp2) begin
            n_fails++;
            $display("FAIL %s rd2 (rr2=%0d): got %h expected %h", e.name, rr2, rd2, e.exp2);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] r;
      rst = 1'b1;
      set_wr(1'b0, 5'd0, 32'h0);
      @(negedge clk);
      rst = 1'b0;

      for (int a = 0; a < 32; a++) read_chk("reset_all", 5'(a), 5'(31 - a));

      set_wr(1'b1, 5'd0, 32'hFFFF_FFFF);
      read_chk("x0_write_bypass", 5'd0, 5'd0);
      set_wr(1'b0, 5'd0, 32'h0);
      read_chk("x0_after_write", 5'd0, 5'd0);

      set_wr(1'b1, 5'd1, 32'h1);
      read_chk("wr_x1", 5'd1, 5'd2);
      set_wr(1'b1, 5'd2, 32'h2);
      read_chk("wr_x2", 5'd2, 5'd1);
      set_wr(1'b1, 5'd7, 32'h12);
      read_chk("wr_x7", 5'd7, 5'd2);
      set_wr(1'b0, 5'd0, 32'h0);
      read_chk("rd_x2_x1", 5'd2, 5'd1);
      read_chk("rd_x7", 5'd2, 5'd7);

      set_wr(1'b0, 5'd7, 32'h99);
      read_chk("wren0_before", 5'd0, 5'd7);
      read_chk("wren0_after", 5'd0, 5'd7);

      set_wr(1'b1, 5'd5, 32'hABCD);
      read_chk("bypass_x5", 5'd5, 5'd5);
      set_wr(1'b0, 5'd0, 32'h0);
      read_chk("x5_stored", 5'd5, 5'd0);

      set_wr(1'b1, 5'd3, 32'h77);
      read_chk("wr_x3", 5'd3, 5'd7);
      rst = 1'b1;
      set_wr(1'b1, 5'd3, 32'h55);
      read_chk("rst_vs_write_nobypass", 5'd3, 5'd5);
      rst = 1'b0;
      set_wr(1'b0, 5'd0, 32'h0);
      read_chk("rst_vs_write_after", 5'd3, 5'd7);

      for (int n = 0; n < 400; n++) begin
         rst = ($urandom_range(0, 59) == 0);
         r = $urandom;
         set_wr(r[0] | r[1], (r[4:2] == 0) ? 5'd0 : 5'($urandom_range(0, 31)), $urandom);
         read_chk("random",
                  (r[6:5] == 0) ? wr : 5'($urandom_range(0, 31)),
                  (r[8:7] == 0) ? wr : ((r[9]) ? rr1 : 5'($urandom_range(0, 31))));
      end
      rst = 1'b0;
      set_wr(1'b0, 5'd0, 32'h0);

      for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clk);
      if (exp_q.size() != 0) begin
         n_checks++;
         n_fails++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule : tb_reg_file

`default_nettype wire

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning register width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 5, meaning register address width; depth is 2**ADDR_W (32).
REQ-003 The block SHALL have parameter BYPASS, default 1, meaning write-to-read forwarding is enabled when 1.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port wren, input, 1 bit: write enable.
REQ-007 The block SHALL have port wd, input, DATA_W bits: write data.
REQ-008 The block SHALL have port rr1, input, ADDR_W bits: read address, port 1.
REQ-009 The block SHALL have port rr2, input, ADDR_W bits: read address, port 2.
REQ-010 The block SHALL have port wr, input, ADDR_W bits: write address.
REQ-011 The block SHALL have port rd1, output, DATA_W bits: read data, port 1.
REQ-012 The block SHALL have port rd2, output, DATA_W bits: read data, port 2.
REQ-013 Port order SHALL be clk, rst, wren, wd, rr1, rr2, wr, rd1, rd2.

Function
REQ-014 The block SHALL hold 2**ADDR_W registers of DATA_W bits (RISC-V x0..x31).
REQ-015 On a rising clk edge with rst=0, wren=1 and wr!=0, the block SHALL write wd into register wr.
REQ-016 When wren=0, no register SHALL change.
REQ-017 Register 0 SHALL be hardwired to zero: writes to it are discarded, and reads of address 0 SHALL return 0 on both ports.
REQ-018 Reads SHALL be combinational (zero latency): rd1 = reg[rr1] and rd2 = reg[rr2].
REQ-019 Both read ports SHALL be independent; rr1 and rr2 may be equal, and both ports then return the same value.
REQ-020 With BYPASS=1, when wren=1, wr!=0, rst=0 and rrN==wr, rdN SHALL return wd in the same cycle (write-through); with BYPASS=0, rdN SHALL return the old value until after the edge.
REQ-021 Bypass SHALL never apply to address 0 and SHALL be suppressed while rst=1.
REQ-022 A write SHALL affect only register wr; all other registers SHALL hold their value.
REQ-023 Outputs SHALL have no X propagation for any in-range address once reset has been applied.

Reset
REQ-024 On a rising clk edge with rst=1, all registers SHALL be cleared to 0, and any simultaneous write SHALL be ignored.
REQ-025 After reset, rd1 and rd2 SHALL read 0 for every address until a new write occurs.
REQ-026 Reset asserted mid-operation SHALL take priority over wren on the same edge.

Structure
REQ-027 DATA_W, ADDR_W and NUM_REGS SHALL be defined in the shared package rv_pkg and used as the parameter defaults.
REQ-028 Read-port logic (address-0 zeroing plus bypass mux) SHALL be one sub-module, reg_file_rdport, instantiated twice.
REQ-029 Storage SHALL be a flop array inferred in reg_file, not a RAM macro, so that the combinational reads are supported.

Verification
REQ-030 Reset test: assert rst for 1 cycle, then read all 32 addresses on rd1 and rd2 -> all read 0x00000000.
REQ-031 x0 test: wren=1, wr=0, wd=0xFFFFFFFF, clock; then rr1=0 -> rd1=0x00000000.
REQ-032 Write/read test: write x1=0x1, x2=0x2, x7=0x12 on successive edges; then rr1=2, rr2=1 -> rd1=0x2, rd2=0x1; rr2=7 -> rd2=0x12.
REQ-033 Disabled write test: wren=0, wr=7, wd=0x99, clock -> rd2 at rr2=7 still reads 0x12.
REQ-034 Bypass test: wren=1, wr=5, wd=0xABCD, rr1=5, before the edge -> rd1=0xABCD (BYPASS=1), or the old value (BYPASS=0).
REQ-035 Reset-vs-write test: rst=1, wren=1, wr=3, wd=0x55, clock -> rd1 at rr1=3 reads 0.
